imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Instruction memory for the single-cycle core, with a byte-stream boot loader in front of it. After reset, it receives a framed program image from a UART receiver's byte stream and writes it into a DEPTH x 32 word array. It holds the core in reset until a complete, checksum-valid image is loaded. The core reads instructions through the combinational address_IMEM/data_IMEM port.

Parameters:
DEPTH, 1024, number of 32-bit instruction words; must equal 2**ADDR_W.
ADDR_W, 10, word-address width; matches address_IMEM.
TIMEOUT_CYCLES, 100000, maximum idle clock cycles allowed between bytes inside a frame.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
CLK  input  1  system clock, rising edge.
RSTn  input  1  asynchronous active-low reset.
rx_data  input  8  received byte; valid only while rx_valid=1.
rx_valid  input  1  single-cycle strobe; one byte is accepted per cycle in which it is high.
address_IMEM  input  ADDR_W  instruction word address from the core.
data_IMEM  output  32  instruction word, read combinationally.
core_RSTn  output  1  active-low reset to the core; registered.
boot_done  output  1  image loaded and verified; registered.
boot_error  output  1  the last frame was rejected; registered.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - FSM state = IDLE.
  - core_RSTn = 0, boot_done = 0, boot_error = 0.
  - Word count, byte index, word index, checksum and timeout counter = 0.
  - The memory array is not reset.
- Frame format, all fields little-endian:
  - SYNC_BYTE.
  - LEN_LO, LEN_HI: 16-bit word count N.
  - 4*N data bytes, least-significant byte of each word first.
  - CSUM: sum of the data bytes only, mod 256.
- State transitions (evaluated on each accepted byte):
  - IDLE: byte == SYNC_BYTE -> LEN_LO; any other byte is ignored.
  - LEN_LO: latch the low byte -> LEN_HI.
  - LEN_HI: latch the high byte. N == 0 or N > DEPTH -> ERROR; otherwise clear the indices and checksum -> DATA.
  - DATA:
    - Shift each byte into the word assembly register and add it to the checksum.
    - On the 4th byte of a word, write mem[word_idx] <= {b3,b2,b1,b0} at that clock edge and increment word_idx.
    - After word N-1 is written -> CSUM.
  - CSUM: byte == checksum -> DONE; otherwise -> ERROR.
  - DONE: all further bytes are ignored and memory is never written. Leaving DONE requires RSTn.
  - ERROR: boot_error = 1. byte == SYNC_BYTE -> LEN_LO, clearing boot_error on that edge; other bytes are ignored.
- Timeout:
  - The counter clears on every accepted byte and increments each idle cycle while in LEN_LO, LEN_HI, DATA or CSUM.
  - Reaching TIMEOUT_CYCLES idle cycles -> ERROR.
  - A byte arriving on the cycle the limit would be reached is accepted and wins.
  - The counter is frozen in IDLE, DONE and ERROR.
- Outputs:
  - core_RSTn and boot_done are set on the same edge the FSM enters DONE, so they are high from the cycle after the CSUM byte.
  - Both stay high until RSTn.
  - core_RSTn never pulses high on a failed frame.
- Read port: data_IMEM = mem[address_IMEM] with no latency. A write and a read to the same address in the same cycle returns the old word until the edge.
- Partial images: words of a rejected frame that were already written remain in memory. Only the next valid frame determines boot_done.
- RSTn asserted mid-frame: immediate return to reset values. Memory keeps any partial contents.

Test Plan:
- Valid load: stream A5 02 00 93 00 50 00 13 01 A0 00 97 -> mem[0]=0x00500093, mem[1]=0x00A00113. core_RSTn and boot_done go 1 one cycle after the 0x97 byte. data_IMEM with address_IMEM=1 reads 0x00A00113.
- Bad checksum: same frame ending in 0x98 -> boot_error=1 and core_RSTn stays 0. Then resend the valid frame -> boot_error clears on A5, and boot_done=1 after 0x97.
- Length bounds:
  - A5 00 00 -> ERROR after LEN_HI.
  - A5 01 04 (N=1025) -> ERROR after LEN_HI.
  - A5 00 04 (N=1024) followed by 4096 bytes and the correct checksum -> DONE, with mem[1023] holding the last word.
- Timeout, two cases with a reduced TIMEOUT_CYCLES=8:
  - Pause of exactly 8 idle cycles after the 3rd data byte -> ERROR.
  - Pause of 7 idle cycles, then the byte -> load continues to DONE.
- Noise and post-boot bytes:
  - 00 FF 5A before A5 -> ignored; the frame loads normally.
  - Bytes A5 01 00 sent after DONE -> mem, core_RSTn and boot_done are unchanged.
- Reset mid-frame: RSTn low during DATA -> core_RSTn=0, boot_done=0, boot_error=0 asynchronously. After release, a fresh valid frame loads to DONE.

Source files
------------

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Instruction memory for the single-cycle core, fronted by a byte-stream boot
// loader. A framed program image arriving from a UART receiver is written into
// a DEPTH x 32 word array. The core is held in reset until a complete image
// with a valid checksum has been loaded.
//
// Frame (little-endian): SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, CSUM
// where CSUM is the mod-256 sum of the data bytes only.
//
// Ports:
//   CLK          - system clock, rising edge
//   RSTn         - asynchronous active-low reset
//   rx_data      - received byte, valid while rx_valid is high
//   rx_valid     - one byte accepted per cycle this strobe is high
//   address_IMEM - instruction word address from the core
//   data_IMEM    - instruction word, read combinationally
//   core_RSTn    - active-low reset to the core (registered)
//   boot_done    - image loaded and verified (registered)
//   boot_error   - last frame was rejected (registered)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          DEPTH          = 1024,
    parameter int          ADDR_W         = 10,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] address_IMEM,
    output logic [31:0]       data_IMEM,
    output logic              core_RSTn,
    output logic              boot_done,
    output logic              boot_error
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     DEPTH_MAX    = 17'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]    state;
    logic [7:0]    len_lo;
    logic [15:0]   word_count;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    checksum;
    logic [23:0]   assembly;
    logic [TW-1:0] timer;

    logic [31:0]   mem [DEPTH];

    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [15:0]   len_full;
    logic          len_bad;
    logic          last_word;
    logic          in_frame;

    // The fourth byte of a word completes it; the three earlier bytes sit in
    // the assembly register with the oldest byte in the low bits.
    assign mem_we    = (state == S_DATA) && rx_valid && (byte_idx == 2'd3);
    assign mem_wdata = {rx_data, assembly};

    assign len_full  = {rx_data, len_lo};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_MAX);
    assign last_word = (word_idx == (word_count - 16'd1));

    // Only the states inside a frame are subject to the inter-byte timeout.
    assign in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);

    // Read-before-write: a same-cycle write only becomes visible after the edge.
    assign data_IMEM = mem[address_IMEM];

    // Memory array is deliberately not reset so a partial image survives RSTn.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[word_idx[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    // Frame parser. The timeout counter clears on every accepted byte, so a
    // byte arriving on the cycle the limit would be reached takes priority.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            len_lo     <= 8'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            checksum   <= 8'd0;
            assembly   <= 24'd0;
            timer      <= '0;
            core_RSTn  <= 1'b0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
        end else if (rx_valid) begin
            timer <= '0;
            case (state)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    len_lo <= rx_data;
                    state  <= S_LEN_HI;
                end
                S_LEN_HI: begin
                    word_count <= len_full;
                    if (len_bad) begin
                        state      <= S_ERROR;
                        boot_error <= 1'b1;
                    end else begin
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                        checksum <= 8'd0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    assembly <= {rx_data, assembly[23:8]};
                    checksum <= checksum + rx_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        word_idx <= word_idx + 16'd1;
                        if (last_word) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_data == checksum) begin
                        state     <= S_DONE;
                        core_RSTn <= 1'b1;
                        boot_done <= 1'b1;
                    end else begin
                        state      <= S_ERROR;
                        boot_error <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state      <= S_LEN_LO;
                        boot_error <= 1'b0;
                    end
                end
                default: begin
                    // DONE is terminal until RSTn; unused encodings hold.
                end
            endcase
        end else if (in_frame) begin
            if (timer == TIMEOUT_LAST) begin
                timer      <= '0;
                state      <= S_ERROR;
                boot_error <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader with a shortened inter-byte timeout.
// Expected memory words are queued as each frame is driven and checked through
// the combinational read port once the frame has completed.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int TMO    = 8;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    logic              CLK;
    logic              RSTn;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] address_IMEM;
    logic [31:0]       data_IMEM;
    logic              core_RSTn;
    logic              boot_done;
    logic              boot_error;

    int          compared;
    int          mismatched;
    exp_t        sb[$];
    logic [31:0] img[$];

    imem_boot_loader #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .address_IMEM (address_IMEM),
        .data_IMEM    (data_IMEM),
        .core_RSTn    (core_RSTn),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic c, input logic d, input logic e);
        check({tag, ".core_RSTn"},  {31'd0, core_RSTn},  {31'd0, c});
        check({tag, ".boot_done"},  {31'd0, boot_done},  {31'd0, d});
        check({tag, ".boot_error"}, {31'd0, boot_error}, {31'd0, e});
    endtask

    // Drives one byte for a single cycle; returns on the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic send_header(input int n);
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    // Sends the data bytes of img plus a checksum. pause_at > 0 inserts
    // pause_len idle cycles after that many data bytes.
    task automatic send_body(input bit good, input bit push, input int pause_at, input int pause_len);
        logic [7:0] sum;
        logic [7:0] b;
        int         cnt;
        sum = 8'd0;
        cnt = 0;
        foreach (img[w]) begin
            if (push) sb.push_back('{w, img[w]});
            for (int k = 0; k < 4; k++) begin
                b = img[w][8*k +: 8];
                sum += b;
                send_byte(b);
                cnt++;
                if (cnt == pause_at) begin
                    idle(pause_len);
                    check("timeout.boot_error", {31'd0, boot_error}, {31'd0, pause_len >= TMO});
                end
            end
        end
        send_byte(good ? sum : sum + 8'd1);
    endtask

    task automatic drain_scoreboard(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            address_IMEM = e.addr[ADDR_W-1:0];
            #1;
            check($sformatf("%s.mem[%0d]", tag, e.addr), data_IMEM, e.data);
        end
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        idle(2);
        RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic load_small();
        img.delete();
        img.push_back(32'h0050_0093);
        img.push_back(32'h00A0_0113);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        address_IMEM = '0;
        RSTn         = 1'b0;
        idle(2);
        check_status("reset", 1'b0, 1'b0, 1'b0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Noise ahead of a valid two-word frame
        load_small();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_header(2);
        send_body(1'b1, 1'b1, 0, 0);
        check_status("valid", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("valid");

        // Bytes after DONE must not disturb anything
        sb.push_back('{0, 32'h0050_0093});
        sb.push_back('{1, 32'h00A0_0113});
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h00);
        check_status("postboot", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("postboot");

        // Bad checksum, then recovery with the valid frame
        do_reset();
        send_header(2);
        send_body(1'b0, 1'b0, 0, 0);
        check_status("badcsum", 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5);
        check("resync.boot_error", {31'd0, boot_error}, 32'd0);
        send_byte(8'h02);
        send_byte(8'h00);
        send_body(1'b1, 1'b1, 0, 0);
        check_status("recover", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("recover");

        // Length bounds
        do_reset();
        send_header(0);
        check_status("len0", 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5);
        check("len1025.sync", {31'd0, boot_error}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h04);
        check_status("len1025", 1'b0, 1'b0, 1'b1);
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        send_header(DEPTH);
        send_body(1'b1, 1'b1, 0, 0);
        check_status("len1024", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("len1024");

        // Timeout: 8 idle cycles aborts, 7 idle cycles survives
        do_reset();
        load_small();
        send_header(2);
        send_body(1'b1, 1'b0, 3, TMO);
        check_status("timeout8", 1'b0, 1'b0, 1'b1);
        send_header(2);
        send_body(1'b1, 1'b1, 3, TMO - 1);
        check_status("timeout7", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("timeout7");

        // Reset asserted mid-frame, between clock edges
        do_reset();
        send_header(2);
        send_byte(8'h93);
        send_byte(8'h00);
        #2;
        RSTn = 1'b0;
        #1;
        check_status("midreset", 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        img.delete();
        img.push_back(32'hDEAD_BEEF);
        img.push_back(32'h1234_5678);
        img.push_back(32'h0000_0013);
        send_header(3);
        send_body(1'b1, 1'b1, 0, 0);
        check_status("afterreset", 1'b1, 1'b1, 1'b0);
        drain_scoreboard("afterreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
